key_conditioner: RTL



---
 rtl/key_conditioner.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronizes active-low keys, debounces each one and emits
// registered level plus press, release and auto-repeat pulses per key.
module key_conditioner #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  localparam logic [DbW-1:0]  DbLimit   = DbW'(DEBOUNCE_CYCLES);
  localparam logic [RepW-1:0] RepDelay  = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepRate   = RepW'(REPEAT_RATE);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } state_e;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [1:0]      r_sync;
    state_e          r_state, w_state_d;
    logic [DbW-1:0]  r_db_cnt, w_db_cnt_d;
    logic [RepW-1:0] r_rep_cnt, w_rep_cnt_d;
    logic            r_rep_phase, w_rep_phase_d;
    logic            r_level, w_level_d;
    logic            r_press, w_press_d;
    logic            r_release, w_release_d;
    logic            r_repeat, w_repeat_d;
    logic            w_pressed;
    logic [RepW-1:0] w_rep_inc;
    logic [RepW-1:0] w_rep_target;

    assign w_pressed    = ~r_sync[1];
    assign w_rep_inc    = r_rep_cnt + RepW'(1);
    // Phase 0 waits out the initial delay, phase 1 runs at the repeat rate.
    assign w_rep_target = r_rep_phase ? RepRate : RepDelay;

    always_comb begin
      w_state_d     = r_state;
      w_db_cnt_d    = r_db_cnt;
      w_rep_cnt_d   = r_rep_cnt;
      w_rep_phase_d = r_rep_phase;
      w_level_d     = r_level;
      w_press_d     = 1'b0;
      w_release_d   = 1'b0;
      w_repeat_d    = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pressed) begin
            w_state_d  = StPressWait;
            w_db_cnt_d = DbW'(1);
          end
        end
        StPressWait: begin
          if (!w_pressed) begin
            w_state_d  = StIdle;
            w_db_cnt_d = '0;
          end else if (r_db_cnt >= DbLimit) begin
            w_state_d     = StHeld;
            w_db_cnt_d    = '0;
            w_press_d     = 1'b1;
            w_level_d     = 1'b1;
            w_rep_cnt_d   = '0;
            w_rep_phase_d = 1'b0;
          end else begin
            w_db_cnt_d = r_db_cnt + DbW'(1);
          end
        end
        StHeld: begin
          if (!w_pressed) begin
            w_state_d  = StReleaseWait;
            w_db_cnt_d = DbW'(1);
          end else if (w_rep_inc == w_rep_target) begin
            w_repeat_d    = REPEAT_EN;
            w_rep_cnt_d   = '0;
            w_rep_phase_d = 1'b1;
          end else begin
            w_rep_cnt_d = w_rep_inc;
          end
        end
        StReleaseWait: begin
          if (w_pressed) begin
            // Release bounce: resume holding with a fresh initial repeat delay.
            w_state_d     = StHeld;
            w_db_cnt_d    = '0;
            w_rep_cnt_d   = '0;
            w_rep_phase_d = 1'b0;
          end else if (r_db_cnt >= DbLimit) begin
            w_state_d   = StIdle;
            w_db_cnt_d  = '0;
            w_release_d = 1'b1;
            w_level_d   = 1'b0;
          end else begin
            w_db_cnt_d = r_db_cnt + DbW'(1);
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_sync      <= 2'b11;
        r_state     <= StIdle;
        r_db_cnt    <= '0;
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_repeat    <= 1'b0;
      end else begin
        r_sync      <= {r_sync[0], key_n[k]};
        r_state     <= w_state_d;
        r_db_cnt    <= w_db_cnt_d;
        r_rep_cnt   <= w_rep_cnt_d;
        r_rep_phase <= w_rep_phase_d;
        r_level     <= w_level_d;
        r_press     <= w_press_d;
        r_release   <= w_release_d;
        r_repeat    <= w_repeat_d;
      end
    end

    assign key_level[k]     = r_level;
    assign press_pulse[k]   = r_press;
    assign release_pulse[k] = r_release;
    assign repeat_pulse[k]  = r_repeat;
  end

endmodule
